// File: rtl/tusca_pkg.sv
// rtl/tusca_pkg.sv - shared state encoding and defaults for the tusca_uc control unit
package tusca_pkg;

  localparam int STATE_W            = 4;
  localparam int MAX_TENTATIVAS_DEF = 3;

  typedef enum logic [STATE_W-1:0] {
    INICIAL        = 4'd0,
    PREPARA        = 4'd1,
    ESPERA         = 4'd2,
    MEDE           = 4'd3,
    AGUARDA_MEDIDA = 4'd4,
    TRANSMITE      = 4'd5,
    AGUARDA_TX     = 4'd6,
    CONFIGURA      = 4'd7,
    AGUARDA_CONFIG = 4'd8,
    FALHA          = 4'd9
  } state_t;

endpackage

// File: rtl/tusca_uc_contadores.sv
// rtl/tusca_uc_contadores.sv - failed-attempt counter and successful-measurement counter
module tusca_uc_contadores
  import tusca_pkg::*;
#(
  parameter int MAX_TENTATIVAS = MAX_TENTATIVAS_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clr_tent,
  input  logic       inc_tent,
  input  logic       inc_med,
  output logic [2:0] tentativas,
  output logic [7:0] n_medidas,
  output logic       limite
);

  // Attempt count clears on success or failure exit; measurement count wraps mod 256
  always_ff @(posedge clock) begin
    if (!reset) begin
      tentativas <= 3'd0;
      n_medidas  <= 8'd0;
    end else begin
      if (clr_tent) begin
        tentativas <= 3'd0;
      end else if (inc_tent) begin
        tentativas <= tentativas + 3'd1;
      end
      if (inc_med) begin
        n_medidas <= n_medidas + 8'd1;
      end
    end
  end

  // True when one more failure would exhaust the allowed attempts
  assign limite = (({1'b0, tentativas} + 4'd1) == 4'(MAX_TENTATIVAS));

endmodule

// File: rtl/tusca_uc.sv
// rtl/tusca_uc.sv - DHT11 measurement control unit (optional config path: TUSCA_UC_CONFIG_EN)
module tusca_uc
  import tusca_pkg::*;
#(
  parameter int MAX_TENTATIVAS = MAX_TENTATIVAS_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ligar,
  input  logic                pedido_config,
  input  logic                fim_delay,
  input  logic                pronto_medida,
  input  logic                erro_medida,
  input  logic                pronto_transmite_medida,
  input  logic                pronto_config,
  input  logic                erro_config,
  output logic                zera_delay,
  output logic                conta_delay,
  output logic                medir_dht11,
  output logic                transmite_medida,
  output logic                receber_config,
  output logic                gira,
  output logic                falha_sensor,
  output logic                erro_config_flag,
  output logic [7:0]          n_medidas,
  output logic [STATE_W-1:0]  db_estado,
  output logic [2:0]          db_tentativas
);

  state_t estado;
  state_t prox;
  logic   clr_tent;
  logic   inc_tent;
  logic   inc_med;
  logic   limite;
  logic   set_err;
  logic   clr_err;

  tusca_uc_contadores #(
    .MAX_TENTATIVAS(MAX_TENTATIVAS)
  ) u_contadores (
    .clock      (clock),
    .reset      (reset),
    .clr_tent   (clr_tent),
    .inc_tent   (inc_tent),
    .inc_med    (inc_med),
    .tentativas (db_tentativas),
    .n_medidas  (n_medidas),
    .limite     (limite)
  );

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado <= INICIAL;
    end else begin
      estado <= prox;
    end
  end

  // Next state and counter strobes; ligar=0 aborts except mid serial transaction
  always_comb begin
    prox     = estado;
    clr_tent = 1'b0;
    inc_tent = 1'b0;
    inc_med  = 1'b0;
    set_err  = 1'b0;
    clr_err  = 1'b0;
    if (!ligar && estado != AGUARDA_TX && estado != AGUARDA_CONFIG) begin
      prox     = INICIAL;
      clr_tent = (estado == FALHA);
    end else begin
      case (estado)
        INICIAL:   prox = PREPARA;
        PREPARA:   prox = ESPERA;
        ESPERA: begin
`ifdef TUSCA_UC_CONFIG_EN
          if (pedido_config) begin
            prox = CONFIGURA;
          end else if (fim_delay) begin
            prox = MEDE;
          end
`else
          if (fim_delay) begin
            prox = MEDE;
          end
`endif
        end
        MEDE:      prox = AGUARDA_MEDIDA;
        AGUARDA_MEDIDA: begin
          if (pronto_medida) begin
            clr_tent = 1'b1;
            inc_med  = 1'b1;
            prox     = TRANSMITE;
          end else if (erro_medida) begin
            if (limite) begin
              prox = FALHA;
            end else begin
              inc_tent = 1'b1;
              prox     = PREPARA;
            end
          end
        end
        TRANSMITE: prox = AGUARDA_TX;
        AGUARDA_TX: begin
          if (pronto_transmite_medida) begin
            prox = ligar ? PREPARA : INICIAL;
          end
        end
`ifdef TUSCA_UC_CONFIG_EN
        CONFIGURA: prox = AGUARDA_CONFIG;
        AGUARDA_CONFIG: begin
          if (erro_config) begin
            set_err = 1'b1;
            prox    = ligar ? PREPARA : INICIAL;
          end else if (pronto_config) begin
            clr_err = 1'b1;
            prox    = ligar ? PREPARA : INICIAL;
          end
        end
`endif
        FALHA:     prox = FALHA;
        default:   prox = INICIAL;
      endcase
    end
  end

  // Moore command decode straight from the state register
  always_comb begin
    zera_delay       = (estado == PREPARA);
    conta_delay      = (estado == ESPERA);
    medir_dht11      = (estado == MEDE);
    transmite_medida = (estado == TRANSMITE);
`ifdef TUSCA_UC_CONFIG_EN
    receber_config   = (estado == CONFIGURA);
`else
    receber_config   = 1'b0;
`endif
    gira             = (estado != INICIAL) && (estado != FALHA);
    falha_sensor     = (estado == FALHA);
  end

  assign db_estado = estado;

`ifdef TUSCA_UC_CONFIG_EN
  // Sticky configuration error; an error wins over a simultaneous success
  always_ff @(posedge clock) begin
    if (!reset) begin
      erro_config_flag <= 1'b0;
    end else if (set_err) begin
      erro_config_flag <= 1'b1;
    end else if (clr_err) begin
      erro_config_flag <= 1'b0;
    end
  end
`else
  logic cfg_unused;
  assign cfg_unused       = pedido_config ^ pronto_config ^ erro_config ^ set_err ^ clr_err;
  assign erro_config_flag = 1'b0;
`endif

endmodule

// File: tb/tb_tusca_uc.sv
// tb/tb_tusca_uc.sv - self-checking bench for tusca_uc (config path follows TUSCA_UC_CONFIG_EN)
module tb_tusca_uc;

  localparam int MAXT = 3;
`ifdef TUSCA_UC_CONFIG_EN
  localparam bit CFG = 1'b1;
`else
  localparam bit CFG = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset, ligar, pedido_config, fim_delay, pronto_medida, erro_medida;
  logic pronto_transmite_medida, pronto_config, erro_config;
  logic zera_delay, conta_delay, medir_dht11, transmite_medida, receber_config;
  logic gira, falha_sensor, erro_config_flag;
  logic [7:0] n_medidas;
  logic [3:0] db_estado;
  logic [2:0] db_tentativas;

  always #5 clock = ~clock;

  tusca_uc #(.MAX_TENTATIVAS(MAXT)) dut (
    .clock(clock), .reset(reset), .ligar(ligar), .pedido_config(pedido_config),
    .fim_delay(fim_delay), .pronto_medida(pronto_medida), .erro_medida(erro_medida),
    .pronto_transmite_medida(pronto_transmite_medida), .pronto_config(pronto_config),
    .erro_config(erro_config), .zera_delay(zera_delay), .conta_delay(conta_delay),
    .medir_dht11(medir_dht11), .transmite_medida(transmite_medida),
    .receber_config(receber_config), .gira(gira), .falha_sensor(falha_sensor),
    .erro_config_flag(erro_config_flag), .n_medidas(n_medidas), .db_estado(db_estado),
    .db_tentativas(db_tentativas)
  );

  typedef struct {
    bit r, l, pd, f, pm, em, ptm, pc, ec;
    int st, t, n;
    bit fl;
  } vec_t;

  vec_t tbl[$];
  int   passed = 0;
  int   total  = 0;
  int   m_st, m_t, m_n;
  bit   m_fl;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  // Expected {zera,conta,medir,transmite,receber,gira,falha} for each state code
  function automatic int exp_cmd(input int st);
    case (st)
      0: return 7'b0000000;
      1: return 7'b1000010;
      2: return 7'b0100010;
      3: return 7'b0010010;
      5: return 7'b0001010;
      7: return 7'b0000110;
      9: return 7'b0000001;
      default: return 7'b0000010;
    endcase
  endfunction

  // Reference behaviour: one clock edge of the control unit's rules
  task automatic model_step(input vec_t v);
    int s = m_st;
    if (!v.r) begin
      m_st = 0; m_t = 0; m_n = 0; m_fl = 0;
      return;
    end
    if (!v.l && s != 6 && s != 8) begin
      if (s == 9) m_t = 0;
      m_st = 0;
      return;
    end
    case (s)
      0: m_st = 1;
      1: m_st = 2;
      2: if (CFG && v.pd) m_st = 7; else if (v.f) m_st = 3;
      3: m_st = 4;
      4: if (v.pm) begin
           m_t = 0; m_n = (m_n + 1) % 256; m_st = 5;
         end else if (v.em) begin
           if (m_t + 1 == MAXT) m_st = 9;
           else begin m_t = m_t + 1; m_st = 1; end
         end
      5: m_st = 6;
      6: if (v.ptm) m_st = v.l ? 1 : 0;
      7: m_st = 8;
      8: if (v.pc || v.ec) begin m_fl = v.ec; m_st = v.l ? 1 : 0; end
      default: ;
    endcase
  endtask

  task automatic apply(input vec_t v);
    @(negedge clock);
    reset = v.r; ligar = v.l; pedido_config = v.pd; fim_delay = v.f;
    pronto_medida = v.pm; erro_medida = v.em; pronto_transmite_medida = v.ptm;
    pronto_config = v.pc; erro_config = v.ec;
    model_step(v);
    @(posedge clock);
    #1;
    chk("state", int'(db_estado), m_st);
    chk("cmd", int'({zera_delay, conta_delay, medir_dht11, transmite_medida,
                     receber_config, gira, falha_sensor}), exp_cmd(m_st));
    chk("tentativas", int'(db_tentativas), m_t);
    chk("n_medidas", int'(n_medidas), m_n);
    chk("erro_config_flag", int'(erro_config_flag), int'(m_fl));
  endtask

  task automatic drive(input bit r, l, pd, f, pm, em, ptm, pc, ec);
    vec_t v;
    v.r = r; v.l = l; v.pd = pd; v.f = f; v.pm = pm; v.em = em;
    v.ptm = ptm; v.pc = pc; v.ec = ec; v.st = 0; v.t = 0; v.n = 0; v.fl = 0;
    apply(v);
  endtask

  task automatic add(input bit r, l, pd, f, pm, em, ptm, pc, ec,
                     input int st, t, n, input bit fl);
    vec_t v;
    v.r = r; v.l = l; v.pd = pd; v.f = f; v.pm = pm; v.em = em;
    v.ptm = ptm; v.pc = pc; v.ec = ec; v.st = st; v.t = t; v.n = n; v.fl = fl;
    tbl.push_back(v);
  endtask

  initial begin
    vec_t v;
    reset = 0; ligar = 1; pedido_config = 0; fim_delay = 0; pronto_medida = 0;
    erro_medida = 0; pronto_transmite_medida = 0; pronto_config = 0; erro_config = 0;
    m_st = 0; m_t = 0; m_n = 0; m_fl = 0;

    //  r l pd f pm em ptm pc ec   st t n fl
    add(0,1,0,0,0,0,0,0,0,  0,0,0,0);
    add(0,1,0,0,0,0,0,0,0,  0,0,0,0);
    add(1,1,0,0,0,0,0,0,0,  1,0,0,0);
    add(1,1,0,0,0,0,0,0,0,  2,0,0,0);
    add(1,1,0,0,0,0,0,0,0,  2,0,0,0);
    add(1,1,0,1,0,0,0,0,0,  3,0,0,0);
    add(1,1,0,0,0,0,0,0,0,  4,0,0,0);
    add(1,1,0,0,0,0,0,0,0,  4,0,0,0);
    add(1,1,0,0,1,1,0,0,0,  5,0,1,0);
    add(1,1,0,0,0,0,0,0,0,  6,0,1,0);
    add(1,1,0,0,0,0,0,0,0,  6,0,1,0);
    add(1,1,0,0,0,0,1,0,0,  1,0,1,0);
    add(1,1,0,0,0,0,0,0,0,  2,0,1,0);
    add(1,1,0,1,0,0,0,0,0,  3,0,1,0);
    add(1,1,0,0,0,0,0,0,0,  4,0,1,0);
    add(1,1,0,0,0,1,0,0,0,  1,1,1,0);
    add(1,1,0,0,0,0,0,0,0,  2,1,1,0);
    add(1,1,0,1,0,0,0,0,0,  3,1,1,0);
    add(1,1,0,0,0,0,0,0,0,  4,1,1,0);
    add(1,1,0,0,0,1,0,0,0,  1,2,1,0);
    add(1,1,0,0,0,0,0,0,0,  2,2,1,0);
    add(1,1,0,1,0,0,0,0,0,  3,2,1,0);
    add(1,1,0,0,0,0,0,0,0,  4,2,1,0);
    add(1,1,0,0,0,1,0,0,0,  9,2,1,0);
    add(1,1,0,0,0,0,0,0,0,  9,2,1,0);
    add(1,0,0,0,0,0,0,0,0,  0,0,1,0);
    add(1,1,0,0,0,0,0,0,0,  1,0,1,0);
    add(1,1,0,0,0,0,0,0,0,  2,0,1,0);
`ifdef TUSCA_UC_CONFIG_EN
    add(1,1,1,1,0,0,0,0,0,  7,0,1,0);
    add(1,1,0,0,0,0,0,0,0,  8,0,1,0);
    add(1,1,0,0,0,0,0,0,1,  1,0,1,1);
    add(1,1,0,0,0,0,0,0,0,  2,0,1,1);
    add(1,1,1,0,0,0,0,0,0,  7,0,1,1);
    add(1,1,0,0,0,0,0,0,0,  8,0,1,1);
    add(1,1,0,0,0,0,0,1,0,  1,0,1,0);
    add(1,1,0,0,0,0,0,0,0,  2,0,1,0);
    add(1,1,1,0,0,0,0,0,0,  7,0,1,0);
    add(1,1,0,0,0,0,0,0,0,  8,0,1,0);
    add(1,1,0,0,0,0,0,1,1,  1,0,1,1);
    add(1,1,0,0,0,0,0,0,0,  2,0,1,1);
    add(1,1,1,0,0,0,0,0,0,  7,0,1,1);
    add(1,1,0,0,0,0,0,0,0,  8,0,1,1);
    add(1,0,0,0,0,0,0,0,0,  8,0,1,1);
    add(1,0,0,0,0,0,0,1,0,  0,0,1,0);
`else
    add(1,1,1,1,0,0,0,0,0,  3,0,1,0);
    add(1,1,0,0,0,0,0,0,0,  4,0,1,0);
    add(1,1,0,0,0,0,0,1,1,  4,0,1,0);
    add(1,1,0,0,1,0,0,0,0,  5,0,2,0);
    add(1,1,0,0,0,0,0,0,0,  6,0,2,0);
    add(1,1,0,0,0,0,1,0,0,  1,0,2,0);
    add(1,1,0,0,0,0,0,0,0,  2,0,2,0);
    add(1,1,1,0,0,0,0,0,0,  2,0,2,0);
    add(1,0,0,0,0,0,0,0,0,  0,0,2,0);
`endif

    foreach (tbl[i]) begin
      apply(tbl[i]);
      chk($sformatf("tbl%0d_state", i), int'(db_estado), tbl[i].st);
      chk($sformatf("tbl%0d_tent", i), int'(db_tentativas), tbl[i].t);
      chk($sformatf("tbl%0d_nmed", i), int'(n_medidas), tbl[i].n);
      chk($sformatf("tbl%0d_flag", i), int'(erro_config_flag), int'(tbl[i].fl));
    end

    // ligar dropped while waiting on the transmitter: hold, then return to INICIAL
    drive(0,1,0,0,0,0,0,0,0);
    drive(1,1,0,0,0,0,0,0,0);
    drive(1,1,0,0,0,0,0,0,0);
    drive(1,1,0,1,0,0,0,0,0);
    drive(1,1,0,0,0,0,0,0,0);
    drive(1,1,0,0,1,0,0,0,0);
    drive(1,1,0,0,0,0,0,0,0);
    for (int k = 0; k < 10; k++) begin
      drive(1,0,0,0,0,0,0,0,0);
      chk("tx_hold", int'(db_estado), 6);
    end
    drive(1,0,0,0,0,0,1,0,0);
    chk("tx_hold_exit", int'(db_estado), 0);

    // n_medidas wraps from 255 to 0
    drive(0,1,0,0,0,0,0,0,0);
    drive(1,1,0,0,0,0,0,0,0);
    for (int k = 1; k <= 256; k++) begin
      drive(1,1,0,0,0,0,0,0,0);
      drive(1,1,0,1,0,0,0,0,0);
      drive(1,1,0,0,0,0,0,0,0);
      drive(1,1,0,0,1,0,0,0,0);
      if (k == 255) chk("nmed_255", int'(n_medidas), 255);
      if (k == 256) chk("nmed_wrap", int'(n_medidas), 0);
      drive(1,1,0,0,0,0,0,0,0);
      drive(1,1,0,0,0,0,1,0,0);
    end
    drive(1,1,0,0,0,0,0,0,0);
    drive(1,1,1,0,0,0,0,0,0);
    chk("pedido_after_wrap", int'(db_estado), CFG ? 7 : 2);

    // Randomized traffic against the reference model
    for (int k = 0; k < 3000; k++) begin
      v.r   = ($urandom_range(0, 63) != 0);
      v.l   = ($urandom_range(0, 15) != 0);
      v.pd  = ($urandom_range(0, 5) == 0);
      v.f   = ($urandom_range(0, 2) == 0);
      v.pm  = ($urandom_range(0, 3) == 0);
      v.em  = ($urandom_range(0, 3) == 0);
      v.ptm = ($urandom_range(0, 3) == 0);
      v.pc  = ($urandom_range(0, 3) == 0);
      v.ec  = ($urandom_range(0, 3) == 0);
      v.st = 0; v.t = 0; v.n = 0; v.fl = 0;
      apply(v);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
